// File: rtl/kbd_input_conditioner_if.sv
// Signal bundle between the raw keypad/button front panel and the microwave controller.
// The master drives the raw panel inputs; the slave (the conditioner) returns clean events.
interface kbd_input_conditioner_if;
  logic [9:0] kbd;
  logic       startn;
  logic       stopn;
  logic       clearn;
  logic       door_closed;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start_pulse;
  logic       stop_pulse;
  logic       clear_pulse;
  logic       door_closed_db;

  modport master (
    output kbd, startn, stopn, clearn, door_closed,
    input  key_valid, key_code, start_pulse, stop_pulse, clear_pulse, door_closed_db
  );

  modport slave (
    input  kbd, startn, stopn, clearn, door_closed,
    output key_valid, key_code, start_pulse, stop_pulse, clear_pulse, door_closed_db
  );
endinterface

// File: rtl/kbd_input_conditioner.sv
// Keypad/button front end: 2-flop synchronisers, per-channel debouncers, a keypad
// IDLE/HELD machine and prioritised single-cycle button strobes.
module kbd_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input logic                   clk,
  input logic                   reset,
  kbd_input_conditioner_if.slave bus
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] DB_MAX  = 8'(DEBOUNCE_CYCLES);

  // Button vector layout: {door, clearn, stopn, startn}; idle is door open, buttons released.
  localparam logic [3:0] BTN_IDLE = 4'b0111;

  typedef enum logic [1:0] {
    KIND_NONE    = 2'd0,
    KIND_DIGIT   = 2'd1,
    KIND_INVALID = 2'd2
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [3:0] idx;
  } kclass_t;

  typedef enum logic {
    IDLE,
    HELD
  } state_e;

  localparam kclass_t KCLASS_NONE = '{kind: KIND_NONE, idx: 4'd0};

  logic [9:0]      kbdMeta_q, kbdSync_q;
  logic [3:0]      btnMeta_q, btnSync_q;
  kclass_t         kbdClass;
  logic [3:0]      kbdOnes, kbdIdx;
  kclass_t         kbdCand_q, kbdStable_q, kbdStable_d;
  logic [7:0]      kbdCnt_q;
  logic [3:0]      btnCand_q, btnStable_q, btnStable_d;
  logic [3:0][7:0] btnCnt_q;
  logic [2:0]      btnFall;
  state_e          state_q;
  logic            keyValid_q;
  logic [3:0]      keyCode_q;
  logic            startPulse_q, stopPulse_q, clearPulse_q;

  // Button synchronisers reset to the idle level so a held button is re-debounced with normal latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      kbdMeta_q <= '0;
      kbdSync_q <= '0;
      btnMeta_q <= BTN_IDLE;
      btnSync_q <= BTN_IDLE;
    end else begin
      kbdMeta_q <= bus.kbd;
      kbdSync_q <= kbdMeta_q;
      btnMeta_q <= {bus.door_closed, bus.clearn, bus.stopn, bus.startn};
      btnSync_q <= btnMeta_q;
    end
  end

  always_comb begin
    kbdOnes  = '0;
    kbdIdx   = '0;
    kbdClass = KCLASS_NONE;
    for (int i = 0; i < 10; i++) begin
      if (kbdSync_q[i]) begin
        kbdOnes = kbdOnes + 4'd1;
        kbdIdx  = 4'(i);
      end
    end
    if (kbdOnes == 4'd1) begin
      kbdClass.kind = KIND_DIGIT;
      kbdClass.idx  = kbdIdx;
    end else if (kbdOnes != 4'd0) begin
      kbdClass.kind = KIND_INVALID;
    end
  end

  // Acceptance is computed combinationally so strobes register on the same edge the count completes.
  always_comb begin
    kbdStable_d = kbdStable_q;
    if ((kbdClass == kbdCand_q) && (kbdCnt_q >= DB_LAST)) begin
      kbdStable_d = kbdCand_q;
    end
    btnStable_d = btnStable_q;
    for (int i = 0; i < 4; i++) begin
      if ((btnSync_q[i] == btnCand_q[i]) && (btnCnt_q[i] >= DB_LAST)) begin
        btnStable_d[i] = btnCand_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kbdCand_q   <= KCLASS_NONE;
      kbdCnt_q    <= '0;
      kbdStable_q <= KCLASS_NONE;
      btnCand_q   <= BTN_IDLE;
      btnCnt_q    <= '0;
      btnStable_q <= BTN_IDLE;
    end else begin
      if (kbdClass != kbdCand_q) begin
        kbdCand_q <= kbdClass;
        kbdCnt_q  <= '0;
      end else if (kbdCnt_q != DB_MAX) begin
        kbdCnt_q <= kbdCnt_q + 8'd1;
      end
      kbdStable_q <= kbdStable_d;
      for (int i = 0; i < 4; i++) begin
        if (btnSync_q[i] != btnCand_q[i]) begin
          btnCand_q[i] <= btnSync_q[i];
          btnCnt_q[i]  <= '0;
        end else if (btnCnt_q[i] != DB_MAX) begin
          btnCnt_q[i] <= btnCnt_q[i] + 8'd1;
        end
      end
      btnStable_q <= btnStable_d;
    end
  end

  // A digit is only accepted from a fully released keypad; roll-over and INVALID stay in HELD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      keyValid_q <= 1'b0;
      keyCode_q  <= 4'd0;
    end else begin
      keyValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (kbdStable_d.kind == KIND_DIGIT) begin
            state_q    <= HELD;
            keyValid_q <= 1'b1;
            keyCode_q  <= kbdStable_d.idx;
          end else if (kbdStable_d.kind == KIND_INVALID) begin
            state_q <= HELD;
          end
        end
        HELD: begin
          if (kbdStable_d.kind == KIND_NONE) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign btnFall = btnStable_q[2:0] & ~btnStable_d[2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      startPulse_q <= 1'b0;
      stopPulse_q  <= 1'b0;
      clearPulse_q <= 1'b0;
    end else begin
      clearPulse_q <= btnFall[2];
      stopPulse_q  <= btnFall[1] & ~btnFall[2];
      startPulse_q <= btnFall[0] & ~btnFall[1] & ~btnFall[2];
    end
  end

  assign bus.key_valid      = keyValid_q;
  assign bus.key_code       = keyCode_q;
  assign bus.start_pulse    = startPulse_q;
  assign bus.stop_pulse     = stopPulse_q;
  assign bus.clear_pulse    = clearPulse_q;
  assign bus.door_closed_db = btnStable_q[3];

endmodule

// File: tb/tb_kbd_input_conditioner.sv
// Directed bench for kbd_input_conditioner: counts strobes and their latency from the
// cycle the raw input changed, and compares them against hand-computed values.
module tb_kbd_input_conditioner;

  localparam int LAT = 7;

  logic clk;
  logic reset;
  int   cycle;
  int   compared;
  int   mismatched;
  int   driveCycle;

  int   keyCnt, startCnt, stopCnt, clearCnt;
  int   lastKeyCycle, lastKeyCode, lastClearCycle, lastStopCycle, lastStartCycle;
  int   doorFallCycle, doorRiseCycle;
  logic prevDoor;

  kbd_input_conditioner_if bus();

  kbd_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index advances on every rising edge; strobe latency is measured in these units.
  always @(posedge clk) cycle = cycle + 1;

  // Strobe monitor samples on the falling edge, away from the register updates.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.key_valid === 1'b1) begin
        keyCnt       = keyCnt + 1;
        lastKeyCycle = cycle;
        lastKeyCode  = int'(bus.key_code);
      end
      if (bus.start_pulse === 1'b1) begin
        startCnt       = startCnt + 1;
        lastStartCycle = cycle;
      end
      if (bus.stop_pulse === 1'b1) begin
        stopCnt       = stopCnt + 1;
        lastStopCycle = cycle;
      end
      if (bus.clear_pulse === 1'b1) begin
        clearCnt       = clearCnt + 1;
        lastClearCycle = cycle;
      end
      if (prevDoor === 1'b1 && bus.door_closed_db === 1'b0) doorFallCycle = cycle;
      if (prevDoor === 1'b0 && bus.door_closed_db === 1'b1) doorRiseCycle = cycle;
    end
    prevDoor = bus.door_closed_db;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared = compared + 1;
    if (observed !== expected) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearCounters();
    keyCnt = 0; startCnt = 0; stopCnt = 0; clearCnt = 0;
    lastKeyCycle = -1000; lastKeyCode = -1;
    lastClearCycle = -1000; lastStopCycle = -1000; lastStartCycle = -1000;
    doorFallCycle = -1000; doorRiseCycle = -1000;
  endtask

  task automatic applyStimulus(input logic [9:0] k, input logic s, input logic st,
                               input logic c, input logic d, input int cycles);
    bus.kbd         = k;
    bus.startn      = s;
    bus.stopn       = st;
    bus.clearn      = c;
    bus.door_closed = d;
    driveCycle      = cycle;
    waitCycles(cycles);
  endtask

  initial begin
    int t0;
    int t1;
    cycle = 0; compared = 0; mismatched = 0; driveCycle = 0;
    prevDoor = 1'b0;
    clearCounters();
    reset           = 1'b1;
    bus.kbd         = '0;
    bus.startn      = 1'b1;
    bus.stopn       = 1'b1;
    bus.clearn      = 1'b1;
    bus.door_closed = 1'b1;

    waitCycles(3);
    @(negedge clk);
    checkOutput("rst key_valid", int'(bus.key_valid), 0);
    checkOutput("rst key_code", int'(bus.key_code), 0);
    checkOutput("rst start_pulse", int'(bus.start_pulse), 0);
    checkOutput("rst stop_pulse", int'(bus.stop_pulse), 0);
    checkOutput("rst clear_pulse", int'(bus.clear_pulse), 0);
    checkOutput("rst door_db", int'(bus.door_closed_db), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    waitCycles(20);
    checkOutput("door settles closed", int'(bus.door_closed_db), 1);
    checkOutput("no strobes after reset", keyCnt + startCnt + stopCnt + clearCnt, 0);

    // Single digit held then released.
    clearCounters();
    applyStimulus(10'b0000000010, 1, 1, 1, 1, 50);
    t0 = driveCycle;
    applyStimulus(10'b0, 1, 1, 1, 1, 20);
    checkOutput("digit1 count", keyCnt, 1);
    checkOutput("digit1 code", lastKeyCode, 1);
    checkOutput("digit1 latency", lastKeyCycle - t0, LAT);
    checkOutput("digit1 code holds", int'(bus.key_code), 1);

    // Bounce rejection, ending on a released segment.
    clearCounters();
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2 == 0) ? 10'b0000000100 : 10'b0, 1, 1, 1, 1, 2);
    end
    checkOutput("bounce no strobe", keyCnt, 0);
    applyStimulus(10'b0000000100, 1, 1, 1, 1, 30);
    t0 = driveCycle;
    checkOutput("bounce count", keyCnt, 1);
    checkOutput("bounce code", lastKeyCode, 2);
    checkOutput("bounce latency", lastKeyCycle - t0, LAT);
    applyStimulus(10'b0, 1, 1, 1, 1, 20);

    // Multi-key and roll-over.
    clearCounters();
    applyStimulus(10'b0000001000, 1, 1, 1, 1, 15);
    t0 = driveCycle;
    applyStimulus(10'b0000101000, 1, 1, 1, 1, 15);
    applyStimulus(10'b0000100000, 1, 1, 1, 1, 15);
    applyStimulus(10'b0, 1, 1, 1, 1, 20);
    checkOutput("rollover count", keyCnt, 1);
    checkOutput("rollover code", lastKeyCode, 3);
    checkOutput("rollover latency", lastKeyCycle - t0, LAT);
    clearCounters();
    applyStimulus(10'b0000100000, 1, 1, 1, 1, 15);
    t0 = driveCycle;
    applyStimulus(10'b0, 1, 1, 1, 1, 20);
    checkOutput("digit5 count", keyCnt, 1);
    checkOutput("digit5 code", lastKeyCode, 5);
    checkOutput("digit5 latency", lastKeyCycle - t0, LAT);

    // Start and clear together: clear wins.
    clearCounters();
    applyStimulus(10'b0, 0, 1, 0, 1, 10);
    t0 = driveCycle;
    applyStimulus(10'b0, 1, 1, 1, 1, 20);
    checkOutput("clr+start clear count", clearCnt, 1);
    checkOutput("clr+start start count", startCnt, 0);
    checkOutput("clr+start stop count", stopCnt, 0);
    checkOutput("clear latency", lastClearCycle - t0, LAT);

    // Short stop glitch is ignored.
    clearCounters();
    applyStimulus(10'b0, 1, 0, 1, 1, 3);
    applyStimulus(10'b0, 1, 1, 1, 1, 20);
    checkOutput("stop glitch count", stopCnt, 0);

    // Stop and start together: stop wins.
    clearCounters();
    applyStimulus(10'b0, 0, 0, 1, 1, 10);
    t0 = driveCycle;
    applyStimulus(10'b0, 1, 1, 1, 1, 20);
    checkOutput("stop+start stop count", stopCnt, 1);
    checkOutput("stop+start start count", startCnt, 0);
    checkOutput("stop latency", lastStopCycle - t0, LAT);

    // Start alone, held long.
    clearCounters();
    applyStimulus(10'b0, 0, 1, 1, 1, 30);
    t0 = driveCycle;
    applyStimulus(10'b0, 1, 1, 1, 1, 20);
    checkOutput("start count", startCnt, 1);
    checkOutput("start latency", lastStartCycle - t0, LAT);

    // Door open then closed.
    clearCounters();
    applyStimulus(10'b0, 1, 1, 1, 0, 100);
    t0 = driveCycle;
    applyStimulus(10'b0, 1, 1, 1, 1, 20);
    t1 = driveCycle;
    checkOutput("door fall latency", doorFallCycle - t0, LAT);
    checkOutput("door rise latency", doorRiseCycle - t1, LAT);
    checkOutput("door no strobes", keyCnt + startCnt + stopCnt + clearCnt, 0);

    // Reset while key 9 is held.
    clearCounters();
    applyStimulus(10'b1000000000, 1, 1, 1, 1, 15);
    checkOutput("key9 count", keyCnt, 1);
    checkOutput("key9 code", lastKeyCode, 9);
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    t1 = cycle;
    clearCounters();
    @(negedge clk);
    checkOutput("reset key_code", int'(bus.key_code), 0);
    waitCycles(20);
    checkOutput("key9 re-count", keyCnt, 1);
    checkOutput("key9 re-code", lastKeyCode, 9);
    checkOutput("key9 re-latency", lastKeyCycle - t1, 4 + 3);
    applyStimulus(10'b0, 1, 1, 1, 1, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
